// File: rtl/tcu_noc_fifo_arb.sv
// rtl/tcu_noc_fifo_arb.sv - per-channel NoC ingress FIFOs with packet-level round-robin arbitration
//
// Buffers flits from NUM_CH sources in one FIFO per channel and forwards only
// complete packets (or a cut-through burst that overflows its FIFO) to a single
// router port. A granted multi-flit packet is never interleaved with another.
//
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   noc_wrreq_i      per-channel flit valid
//   noc_burst_i      per-channel burst bit (1 = more flits follow)
//   noc_flit_i       per-channel flits, channel c at [c*FLIT_WIDTH +: FLIT_WIDTH]
//   noc_stall_o      per-channel backpressure to the sources
//   noc_wrreq_o      output flit valid
//   noc_burst_o      output burst bit
//   noc_flit_o       output flit (show-ahead from the selected FIFO head)
//   noc_chsel_o      channel index of the output flit
//   noc_stall_i      router backpressure
//   cut_through_o    sticky per-channel flag, set once cut-through was used
module tcu_noc_fifo_arb #(
  parameter int NUM_CH         = 3,
  parameter int FLIT_WIDTH     = 160,
  parameter int FIFO_DEPTH     = 4,
  parameter bit NOC_MASTER     = 1'b0,
  parameter bit CUT_THROUGH_EN = 1'b1,
  localparam int CHW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_CH-1:0]            noc_wrreq_i,
  input  logic [NUM_CH-1:0]            noc_burst_i,
  input  logic [NUM_CH*FLIT_WIDTH-1:0] noc_flit_i,
  output logic [NUM_CH-1:0]            noc_stall_o,
  output logic                         noc_wrreq_o,
  output logic                         noc_burst_o,
  output logic [FLIT_WIDTH-1:0]        noc_flit_o,
  output logic [CHW-1:0]               noc_chsel_o,
  input  logic                         noc_stall_i,
  output logic [NUM_CH-1:0]            cut_through_o
);

  localparam int ENTRIES = 1 << FIFO_DEPTH;
  localparam int PW      = FIFO_DEPTH + 1;

  // Each entry stores {burst, flit}.
  logic [FLIT_WIDTH:0]   mem     [NUM_CH][ENTRIES];
  logic [FIFO_DEPTH-1:0] wr_ptr  [NUM_CH];
  logic [FIFO_DEPTH-1:0] rd_ptr  [NUM_CH];
  logic [PW-1:0]         count   [NUM_CH];
  logic [PW-1:0]         pkt_cnt [NUM_CH];

  logic [NUM_CH-1:0] full, empty, push, pop, head_burst, elig, ct_elig;
  logic [NUM_CH-1:0] ct_seen;
  logic              locked;
  logic [CHW-1:0]    lock_ch, rr_ptr, sel;
  logic              any_elig;

  always_comb begin
    int idx;
    idx      = 0;
    sel      = '0;
    any_elig = 1'b0;
    pop      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]       = (count[c] == PW'(ENTRIES));
      empty[c]      = (count[c] == '0);
      push[c]       = noc_wrreq_i[c] & ~full[c];
      head_burst[c] = mem[c][rd_ptr[c]][FLIT_WIDTH];
      // A full FIFO without a single complete packet can only drain by
      // forwarding the partial burst it holds.
      ct_elig[c]    = CUT_THROUGH_EN && full[c] && (pkt_cnt[c] == '0);
      elig[c]       = !empty[c] && ((pkt_cnt[c] != '0) || ct_elig[c]);
    end
    if (locked) begin
      sel = lock_ch;
    end else begin
      // Walk from the farthest to the nearest candidate so the channel right
      // after rr_ptr ends up as the winner.
      for (int i = NUM_CH; i >= 1; i--) begin
        idx = (int'(rr_ptr) + i) % NUM_CH;
        if (elig[idx]) begin
          sel      = CHW'(idx);
          any_elig = 1'b1;
        end
      end
    end
    noc_wrreq_o = locked ? !empty[lock_ch] : any_elig;
    if (noc_wrreq_o && !noc_stall_i) pop[sel] = 1'b1;
  end

  assign noc_flit_o    = mem[sel][rd_ptr[sel]][FLIT_WIDTH-1:0];
  assign noc_burst_o   = noc_wrreq_o & head_burst[sel];
  assign noc_chsel_o   = sel;
  assign noc_stall_o   = NOC_MASTER ? (full | ~noc_wrreq_i) : full;
  assign cut_through_o = ct_seen | ct_elig;

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c]] <= {noc_burst_i[c], noc_flit_i[c*FLIT_WIDTH +: FLIT_WIDTH]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]  <= '0;
        rd_ptr[c]  <= '0;
        count[c]   <= '0;
        pkt_cnt[c] <= '0;
      end
      locked  <= 1'b0;
      lock_ch <= '0;
      rr_ptr  <= CHW'(NUM_CH - 1);
      ct_seen <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        count[c] <= count[c] + PW'(push[c]) - PW'(pop[c]);
        // Single flits and tails both carry burst=0, so the burst bit alone
        // marks the end of a packet on push and on pop.
        if ((push[c] && !noc_burst_i[c]) && !(pop[c] && !head_burst[c]))
          pkt_cnt[c] <= pkt_cnt[c] + 1'b1;
        else if (!(push[c] && !noc_burst_i[c]) && (pop[c] && !head_burst[c]))
          pkt_cnt[c] <= pkt_cnt[c] - 1'b1;
      end
      ct_seen <= ct_seen | ct_elig;
      if (noc_wrreq_o && !noc_stall_i) begin
        if (!head_burst[sel]) begin
          locked <= 1'b0;
          rr_ptr <= sel;
        end else if (!locked) begin
          locked  <= 1'b1;
          lock_ch <= sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_tcu_noc_fifo_arb.sv
// tb/tb_tcu_noc_fifo_arb.sv - self-checking bench for tcu_noc_fifo_arb
module tb_tcu_noc_fifo_arb;
  localparam int NCH   = 3;
  localparam int FW    = 160;
  localparam int DEPTH = 16;

  typedef logic [FW:0] ent_t;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic reset_i = 1'b1;

  logic [NCH-1:0]    a_wrreq = '0, a_burst = '0;
  logic [NCH*FW-1:0] a_flit = '0;
  logic [NCH-1:0]    a_stall_o, a_ct_o;
  logic              a_wr_o, a_burst_o, a_stall_i = 1'b0;
  logic [FW-1:0]     a_flit_o;
  logic [1:0]        a_chsel_o;

  logic [NCH-1:0]    b_wrreq = '0, b_burst = '0;
  logic [NCH*FW-1:0] b_flit = '0;
  logic              b_stall_i = 1'b0;
  logic [NCH-1:0]    b_stall_o, b_ct_o, c_stall_o, c_ct_o;
  logic              b_wr_o, b_burst_o, c_wr_o, c_burst_o;
  logic [FW-1:0]     b_flit_o, c_flit_o;
  logic [1:0]        b_chsel_o, c_chsel_o;

  tcu_noc_fifo_arb dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .noc_wrreq_i(a_wrreq), .noc_burst_i(a_burst),
    .noc_flit_i(a_flit), .noc_stall_o(a_stall_o), .noc_wrreq_o(a_wr_o), .noc_burst_o(a_burst_o),
    .noc_flit_o(a_flit_o), .noc_chsel_o(a_chsel_o), .noc_stall_i(a_stall_i), .cut_through_o(a_ct_o));

  tcu_noc_fifo_arb #(.FIFO_DEPTH(2), .CUT_THROUGH_EN(1'b1)) dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .noc_wrreq_i(b_wrreq), .noc_burst_i(b_burst),
    .noc_flit_i(b_flit), .noc_stall_o(b_stall_o), .noc_wrreq_o(b_wr_o), .noc_burst_o(b_burst_o),
    .noc_flit_o(b_flit_o), .noc_chsel_o(b_chsel_o), .noc_stall_i(b_stall_i), .cut_through_o(b_ct_o));

  tcu_noc_fifo_arb #(.FIFO_DEPTH(2), .CUT_THROUGH_EN(1'b0)) dut_c (
    .clk_i(clk_i), .reset_i(reset_i), .noc_wrreq_i(b_wrreq), .noc_burst_i(b_burst),
    .noc_flit_i(b_flit), .noc_stall_o(c_stall_o), .noc_wrreq_o(c_wr_o), .noc_burst_o(c_burst_o),
    .noc_flit_o(c_flit_o), .noc_chsel_o(c_chsel_o), .noc_stall_i(b_stall_i), .cut_through_o(c_ct_o));

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: per-channel queues of buffered flits plus packet-level lock state.
  ent_t     mq[NCH][$];
  ent_t     src_q[NCH][$];
  bit       m_locked;
  int       m_lock, m_rr;
  logic [NCH-1:0] m_ct;

  int  cyc, obs_pops;
  bit  rand_mode;
  int  stall_from, stall_to;
  int  src_delay[NCH];
  logic log_wr[64];
  int  log_ch[64];

  task automatic check(input string tag, input logic [FW:0] obs, input logic [FW:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_done(input int c);
    int n;
    ent_t e;
    n = 0;
    for (int i = 0; i < mq[c].size(); i++) begin
      e = mq[c][i];
      if (!e[FW]) n++;
    end
    return n;
  endfunction

  function automatic logic [FW-1:0] rnd_flit();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic add_pkt(input int c, input int len);
    for (int i = 0; i < len; i++) src_q[c].push_back({(i < len - 1) ? 1'b1 : 1'b0, rnd_flit()});
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1;
    a_wrreq = '0; a_burst = '0; a_stall_i = 1'b0;
    b_wrreq = '0; b_burst = '0; b_stall_i = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      src_q[c].delete();
      mq[c].delete();
      src_delay[c] = 0;
    end
    @(negedge clk_i);
    reset_i   = 1'b0;
    m_locked  = 1'b0;
    m_lock    = 0;
    m_rr      = NCH - 1;
    m_ct      = '0;
    cyc       = 0;
    obs_pops  = 0;
    rand_mode = 1'b0;
    stall_from = 1000;
    stall_to   = 0;
    #1;
    check("reset wrreq_o", a_wr_o, 0);
    check("reset burst_o", a_burst_o, 0);
    check("reset chsel_o", a_chsel_o, 0);
    check("reset stall_o", a_stall_o, 0);
    check("reset cut_through_o", a_ct_o, 0);
  endtask

  task automatic step();
    bit e_wr;
    int e_sel, k;
    logic [NCH-1:0] e_full, e_ctn;
    ent_t head;
    @(negedge clk_i);
    for (int c = 0; c < NCH; c++) begin
      if (src_q[c].size() > 0 && cyc >= src_delay[c] && (!rand_mode || $urandom_range(3) != 0)) begin
        head = src_q[c][0];
        a_wrreq[c] = 1'b1;
        a_burst[c] = head[FW];
        a_flit[c*FW +: FW] = head[FW-1:0];
      end else begin
        a_wrreq[c] = 1'b0;
        a_burst[c] = 1'b0;
      end
    end
    a_stall_i = rand_mode ? ($urandom_range(3) == 0) : (cyc >= stall_from && cyc <= stall_to);
    #1;
    for (int c = 0; c < NCH; c++) begin
      e_full[c] = (mq[c].size() == DEPTH);
      e_ctn[c]  = e_full[c] && (cnt_done(c) == 0);
    end
    m_ct  = m_ct | e_ctn;
    e_wr  = 1'b0;
    e_sel = 0;
    if (m_locked) begin
      e_sel = m_lock;
      e_wr  = (mq[m_lock].size() > 0);
    end else begin
      for (int i = 1; i <= NCH; i++) begin
        k = (m_rr + i) % NCH;
        if (!e_wr && mq[k].size() > 0 && (cnt_done(k) > 0 || e_ctn[k])) begin
          e_wr  = 1'b1;
          e_sel = k;
        end
      end
    end
    check("wrreq_o", a_wr_o, e_wr);
    check("stall_o", a_stall_o, e_full);
    check("cut_through_o", a_ct_o, m_ct);
    if (e_wr) begin
      head = mq[e_sel][0];
      check("chsel_o", a_chsel_o, e_sel);
      check("burst_o", a_burst_o, head[FW]);
      check("flit_o", a_flit_o, head[FW-1:0]);
    end else begin
      check("idle burst_o", a_burst_o, 0);
    end
    if (cyc < 64) begin
      log_wr[cyc] = a_wr_o;
      log_ch[cyc] = a_chsel_o;
    end
    if (a_wr_o && !a_stall_i) obs_pops++;
    if (e_wr && !a_stall_i) begin
      head = mq[e_sel].pop_front();
      if (!head[FW]) begin
        m_locked = 1'b0;
        m_rr     = e_sel;
      end else if (!m_locked) begin
        m_locked = 1'b1;
        m_lock   = e_sel;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (a_wrreq[c] && !e_full[c]) mq[c].push_back(src_q[c].pop_front());
    end
    cyc++;
  endtask

  initial begin
    ent_t ctf[6];
    int   idx, guard;
    bit   busy;

    // Single flits on all channels: served 0, 1, 2 in consecutive cycles.
    do_reset();
    add_pkt(0, 1); add_pkt(1, 1); add_pkt(2, 1);
    repeat (6) step();
    check("t1 idle cycle0", log_wr[0], 0);
    for (int i = 1; i <= 3; i++) begin
      check("t1 wrreq", log_wr[i], 1);
      check("t1 chsel", log_ch[i], i - 1);
    end

    // Burst hold: ch1 single first, ch0 4-flit burst from cycle 4.
    do_reset();
    add_pkt(0, 4); add_pkt(1, 1);
    repeat (10) step();
    check("t2 ch1 wrreq", log_wr[1], 1);
    check("t2 ch1 chsel", log_ch[1], 1);
    check("t2 gap2", log_wr[2], 0);
    check("t2 gap3", log_wr[3], 0);
    for (int i = 4; i <= 7; i++) begin
      check("t2 burst wrreq", log_wr[i], 1);
      check("t2 burst chsel", log_ch[i], 0);
    end
    check("t2 done", log_wr[8], 0);

    // Interleave protection: ch1 completes while ch0 is locked mid-burst.
    do_reset();
    add_pkt(0, 4);
    add_pkt(1, 1);
    src_delay[1] = 5;
    repeat (11) step();
    for (int i = 4; i <= 7; i++) check("t3 locked chsel", log_ch[i], 0);
    check("t3 ch1 wrreq", log_wr[8], 1);
    check("t3 ch1 chsel", log_ch[8], 1);

    // Backpressure mid-burst for 5 cycles.
    do_reset();
    add_pkt(0, 6);
    stall_from = 6;
    stall_to   = 10;
    repeat (18) step();
    check("t4 stalled wrreq", log_wr[10], 1);
    check("t4 pops", obs_pops, 6);

    // Cut-through on 4-entry FIFOs: 6-flit burst on ch2.
    do_reset();
    for (int i = 0; i < 6; i++) ctf[i] = {(i < 5) ? 1'b1 : 1'b0, rnd_flit()};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      idx = (k < 4) ? k : ((k < 6) ? 4 : ((k == 6) ? 5 : -1));
      b_wrreq = '0;
      b_burst = '0;
      if (idx >= 0) begin
        b_wrreq[2] = 1'b1;
        b_burst[2] = ctf[idx][FW];
        b_flit[2*FW +: FW] = ctf[idx][FW-1:0];
      end
      #1;
      check("ct wrreq_o", b_wr_o, (k >= 4 && k <= 9));
      if (k >= 4 && k <= 9) begin
        check("ct chsel_o", b_chsel_o, 2);
        check("ct flit_o", b_flit_o, ctf[k-4][FW-1:0]);
        check("ct burst_o", b_burst_o, (k < 9));
      end
      check("ct flag", b_ct_o, (k >= 4) ? 3'b100 : 3'b000);
      check("ct stall_o", b_stall_o[2], (k == 4));
      check("noct wrreq_o", c_wr_o, 0);
      check("noct stall_o", c_stall_o[2], (k >= 4));
    end

    // Reset with 2 of 4 burst flits buffered, then a fresh single on ch1.
    do_reset();
    add_pkt(0, 4);
    repeat (2) step();
    do_reset();
    add_pkt(1, 1);
    repeat (4) step();
    check("t6 idle", log_wr[0], 0);
    check("t6 wrreq", log_wr[1], 1);
    check("t6 chsel", log_ch[1], 1);
    check("t6 after", log_wr[2], 0);

    // Randomized traffic, bursts up to 20 flits to exercise cut-through.
    do_reset();
    rand_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++)
        if (src_q[c].size() == 0 && $urandom_range(1) == 0) add_pkt(c, $urandom_range(1, 20));
      step();
    end
    guard = 0;
    busy  = 1'b1;
    while (busy && guard < 3000) begin
      step();
      guard++;
      busy = 1'b0;
      for (int c = 0; c < NCH; c++) if (src_q[c].size() > 0 || mq[c].size() > 0) busy = 1'b1;
    end
    check("random drain", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
